aes_decrypt_iter: RTL and testbench



---
 rtl/aes_decrypt_iter.sv | 173 +++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, valid/ready on both sides.
// Ports: clk/rst_n (sync active-low); in_valid/in_ready/cipher_text capture a block;
//        expanded_key carries all 11 round keys (round r at [128*r +: 128], round 0 first);
//        out_valid/out_ready/plain_text return the result; busy is high while rounds run.
module aes_decrypt_iter #(
  parameter int ROUNDS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              cipher_text,
  input  logic [0:128*(ROUNDS+1)-1] expanded_key,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              plain_text,
  output logic                      busy
);

  if (ROUNDS != 10) begin : g_rounds_check
    $error("aes_decrypt_iter supports only ROUNDS == 10");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    logic [7:0] m;
    p = 8'h00;
    t = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ t;
      t = xtime(t);
      m = m >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] pt_q, pt_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [127:0] rk [ROUNDS+1];
  logic [127:0] isr, isb, ark, round_out;

  for (genvar r = 0; r <= ROUNDS; r++) begin : g_rk
    assign rk[r] = expanded_key[128*r +: 128];
  end

  // Byte b sits at row b%4, column b/4; inverse ShiftRows rotates row r right by r.
  for (genvar b = 0; b < 16; b++) begin : g_byte
    localparam int ROW = b % 4;
    localparam int COL = b / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign isr[127-8*b -: 8] = state_q[127-8*SRC -: 8];
    assign isb[127-8*b -: 8] = inv_sbox(isr[127-8*b -: 8]);
  end

  assign ark = isb ^ rk[cnt_q];

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*c -: 8];
    assign a1 = ark[119-32*c -: 8];
    assign a2 = ark[111-32*c -: 8];
    assign a3 = ark[103-32*c -: 8];
    assign round_out[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign round_out[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign round_out[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign round_out[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  // Gated by rst_n so the core never advertises readiness while held in reset.
  assign in_ready = rst_n && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = cipher_text ^ rk[ROUNDS];
          cnt_d   = 4'(ROUNDS - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (cnt_q == 4'd1) fsm_d = FINAL;
        else               cnt_d = cnt_q - 4'd1;
      end
      FINAL: begin
        pt_d        = isb ^ rk[0];
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Result consumed; a waiting block is taken in the same cycle.
          if (in_valid) begin
            state_d = cipher_text ^ rk[ROUNDS];
            cnt_d   = 4'(ROUNDS - 1);
            fsm_d   = ROUND;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
    busy_d = (fsm_d == ROUND) || (fsm_d == FINAL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      cnt_q       <= 4'd0;
      state_q     <= 128'd0;
      pt_q        <= 128'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign plain_text = pt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using FIPS-197 App B and App C.1 vectors.
// Key schedules come from a forward key-expansion model; plaintexts are the published constants.
module tb_aes_decrypt_iter;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   cipher_text;
  logic [0:1407]  expanded_key;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   plain_text;
  logic           busy;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic [1407:0] ek_b, ek_c;

  always #5 clk = ~clk;

  aes_decrypt_iter #(.ROUNDS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cipher_text  (cipher_text),
    .expanded_key (expanded_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .plain_text   (plain_text),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Forward S-box model: brute-force field inverse followed by the affine map.
  function automatic logic [7:0] m_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t, m;
    p = 8'h00; t = a; m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ t;
      t = m_xtime(t);
      m = m >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (m_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w0, w1, w2, w3, t;
    logic [7:0]    rc;
    logic [1407:0] acc;
    w0 = key[127:96]; w1 = key[95:64]; w2 = key[63:32]; w3 = key[31:0];
    acc = {1280'd0, key};
    rc  = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t  = {m_sbox(w3[23:16]), m_sbox(w3[15:8]), m_sbox(w3[7:0]), m_sbox(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      acc = {acc[1279:0], w0, w1, w2, w3};
      rc  = m_xtime(rc);
    end
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until out_valid and how many of them had busy high; bounded.
  task automatic wait_out(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic start_block(input string tag, input logic [127:0] ct, input logic [1407:0] ek);
    cipher_text  = ct;
    expanded_key = ek;
    in_valid     = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [127:0] ct, input logic [1407:0] ek,
                         input logic [127:0] pt);
    int lat, bcnt;
    out_ready = 1'b1;
    start_block(tag, ct, ek);
    wait_out(lat, bcnt);
    check_eq({tag, "_latency"}, 128'(lat), 128'd10);
    check_eq({tag, "_busy_cycles"}, 128'(bcnt), 128'd10);
    check_eq({tag, "_plain"}, plain_text, pt);
    step();
    check_eq({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
    check_eq({tag, "_idle_ready"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bcnt;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    cipher_text  = '0;
    expanded_key = '0;
    ek_b = expand_key(KEY_B);
    ek_c = expand_key(KEY_C);

    // Reset state.
    step();
    step();
    check_eq("rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_plain", plain_text, 128'd0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Single blocks, consumer always ready.
    run_one("appb", CT_B, ek_b, PT_B);
    run_one("appc", CT_C, ek_c, PT_C);

    // Backpressure: result held for 20 cycles.
    out_ready = 1'b0;
    start_block("bp", CT_B, ek_b);
    wait_out(lat, bcnt);
    check_eq("bp_latency", 128'(lat), 128'd10);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("bp_valid_hold", 128'(out_valid), 128'd1);
      check_eq("bp_plain_hold", plain_text, PT_B);
      check_eq("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_on_accept", 128'(in_ready), 128'd1);
    step();
    check_eq("bp_valid_drop", 128'(out_valid), 128'd0);
    check_eq("bp_idle_ready", 128'(in_ready), 128'd1);

    // Back-to-back: second block taken in the DONE cycle.
    out_ready    = 1'b1;
    cipher_text  = CT_B;
    expanded_key = ek_b;
    in_valid     = 1'b1;
    step();
    wait_out(lat, bcnt);
    check_eq("b2b_first_latency", 128'(lat), 128'd10);
    check_eq("b2b_first_plain", plain_text, PT_B);
    cipher_text  = CT_C;
    expanded_key = ek_c;
    #1;
    check_eq("b2b_ready_in_done", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check_eq("b2b_valid_drop", 128'(out_valid), 128'd0);
    check_eq("b2b_second_busy", 128'(busy), 128'd1);
    wait_out(lat, bcnt);
    check_eq("b2b_second_latency", 128'(lat), 128'd10);
    check_eq("b2b_second_plain", plain_text, PT_C);
    step();
    check_eq("b2b_end_valid", 128'(out_valid), 128'd0);

    // Reset in the middle of the rounds.
    start_block("mid", CT_B, ek_b);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("midrst_out_valid", 128'(out_valid), 128'd0);
    check_eq("midrst_busy", 128'(busy), 128'd0);
    check_eq("midrst_plain", plain_text, 128'd0);
    check_eq("midrst_in_ready", 128'(in_ready), 128'd1);
    run_one("after_rst", CT_B, ek_b, PT_B);

    // in_valid pulsed with garbage while busy must be ignored.
    start_block("ign", CT_B, ek_b);
    repeat (3) step();
    cipher_text = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat, bcnt);
    check_eq("ign_latency", 128'(lat), 128'd6);
    check_eq("ign_plain", plain_text, PT_B);
    step();
    check_eq("ign_valid_drop", 128'(out_valid), 128'd0);
    repeat (3) step();
    check_eq("ign_no_capture_busy", 128'(busy), 128'd0);
    check_eq("ign_no_capture_valid", 128'(out_valid), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
